period_seq_checker: RTL and testbench

- Receive-side checker for the segmented counter sequencer.
- Watches the sequencer's wrap strobe, measures the clock cycles between wraps, and checks the intervals against the fixed period sequence 13, 4, 2, 6, 11 (counts 0..12, 0..3, 0..1, 0..5, 0..10).
- Finds its place in the sequence, reports lock, and flags every deviation.
- Sits beside the sequencer on the same clock, as a self-check and status monitor.

---
 rtl/period_seq_pkg.sv | 51 +++++
 rtl/period_seq_checker_if.sv | 22 ++
 rtl/interval_meter.sv | 56 +++++
 rtl/period_seq_checker.sv | 194 +++++++++++++++++++
 tb/tb_period_seq_checker.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/period_seq_pkg.sv
// -----------------------------------------------------------------------------
// period_seq_pkg
// Shared definitions for the segmented counter sequencer and its receive-side
// checker: checker FSM state encoding, default segment periods, segment count
// and small helpers used by both sides.
// No ports (package).
// -----------------------------------------------------------------------------
package period_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam int NUM_SEG     = 5;
  localparam int DEF_PERIOD0 = 13;
  localparam int DEF_PERIOD1 = 4;
  localparam int DEF_PERIOD2 = 2;
  localparam int DEF_PERIOD3 = 6;
  localparam int DEF_PERIOD4 = 11;

  // Segment index successor, wrapping 4 -> 0.
  function automatic logic [2:0] next_seg(input logic [2:0] idx);
    logic [2:0] nxt;
    if (idx >= 3'd4) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

  // True when all five periods are at least 1 and pairwise distinct.
  function automatic bit periods_ok(input int p0, input int p1, input int p2,
                                    input int p3, input int p4);
    int p [NUM_SEG];
    bit ok;
    p  = '{p0, p1, p2, p3, p4};
    ok = 1'b1;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (p[i] < 1) ok = 1'b0;
      for (int j = i + 1; j < NUM_SEG; j++) begin
        if (p[i] == p[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/period_seq_checker_if.sv
// -----------------------------------------------------------------------------
// period_seq_checker_if
// Bundle between the sequencer side (master: drives the wrap strobe, observes
// status) and the checker (slave: samples tick, drives status).
//   tick      wrap strobe, one event per high cycle
//   locked    sequence locked
//   err       one-cycle violation pulse
//   seg_idx   segment expected to end at the next tick (0..4)
//   last_len  most recent measured interval (CW bits)
// -----------------------------------------------------------------------------
interface period_seq_checker_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          locked;
  logic          err;
  logic [2:0]    seg_idx;
  logic [CW-1:0] last_len;

  modport master (output tick, input locked, err, seg_idx, last_len);
  modport slave  (input tick, output locked, err, seg_idx, last_len);
endinterface

// File: rtl/interval_meter.sv
// -----------------------------------------------------------------------------
// interval_meter
// Counts cycles since the last tick. On a tick cycle it presents the interval
// L = gap+1 (saturating at 2^CW-1) with a valid strobe and reloads gap to 0.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   tick           wrap strobe
//   len            interval ending at this tick (valid with len_valid)
//   len_valid      tick-qualified strobe for len
//   gap_at_max     gap has reached MAX_GAP with no tick this cycle
// -----------------------------------------------------------------------------
module interval_meter #(
  parameter int CW      = 8,
  parameter int MAX_GAP = 64
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  output logic [CW-1:0] len,
  output logic          len_valid,
  output logic          gap_at_max
);
  localparam logic [CW-1:0] SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LIMIT = CW'(MAX_GAP);

  logic [CW-1:0] gap_q;
  logic [CW-1:0] gap_d;

  // Next gap: reload on tick, otherwise count up and hold at saturation.
  always_comb begin
    gap_d = gap_q;
    if (tick) begin
      gap_d = '0;
    end else if (gap_q != SAT) begin
      gap_d = gap_q + ONE;
    end else begin
      gap_d = SAT;
    end
  end

  // Gap counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  // A saturated gap yields a saturated L so a stall can never alias a period.
  assign len        = (gap_q == SAT) ? SAT : (gap_q + ONE);
  assign len_valid  = tick;
  assign gap_at_max = (gap_q == LIMIT) && !tick;

endmodule

// File: rtl/period_seq_checker.sv
// -----------------------------------------------------------------------------
// period_seq_checker
// Receive-side checker for the segmented counter sequencer. Measures the
// interval between wrap strobes, locates its position in the period sequence
// PERIOD0..PERIOD4, reports lock and pulses err on every deviation.
// Optional feature macro: PERIOD_CHK_TIMEOUT_EN -- when defined, a gap of
// MAX_GAP cycles with no tick in TRACK/LOCKED raises err and returns to IDLE.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   bus (slave)    tick in; locked, err, seg_idx, last_len out (all registered)
// -----------------------------------------------------------------------------
module period_seq_checker
  import period_seq_pkg::*;
#(
  parameter int PERIOD0    = DEF_PERIOD0,
  parameter int PERIOD1    = DEF_PERIOD1,
  parameter int PERIOD2    = DEF_PERIOD2,
  parameter int PERIOD3    = DEF_PERIOD3,
  parameter int PERIOD4    = DEF_PERIOD4,
  parameter int CW         = 8,
  parameter int LOCK_COUNT = 5,
  parameter int MAX_GAP    = 64
) (
  input logic                 clock,
  input logic                 reset,
  period_seq_checker_if.slave bus
);
  localparam int            MRW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] SAT = {CW{1'b1}};

  if (!periods_ok(PERIOD0, PERIOD1, PERIOD2, PERIOD3, PERIOD4)) begin : g_bad_periods
    $error("period_seq_checker: PERIOD0..4 must be distinct and >= 1");
  end

  function automatic logic [CW-1:0] period_at(input logic [2:0] idx);
    logic [CW-1:0] p;
    case (idx)
      3'd0:    p = CW'(PERIOD0);
      3'd1:    p = CW'(PERIOD1);
      3'd2:    p = CW'(PERIOD2);
      3'd3:    p = CW'(PERIOD3);
      3'd4:    p = CW'(PERIOD4);
      default: p = '0;
    endcase
    return p;
  endfunction

  logic [CW-1:0] len_s;
  logic          len_valid_s;
  logic          gap_at_max_s;

  interval_meter #(.CW(CW), .MAX_GAP(MAX_GAP)) u_meter (
    .clock      (clock),
    .reset      (reset),
    .tick       (bus.tick),
    .len        (len_s),
    .len_valid  (len_valid_s),
    .gap_at_max (gap_at_max_s)
  );

`ifndef PERIOD_CHK_TIMEOUT_EN
  logic unused_timeout_s;
  assign unused_timeout_s = gap_at_max_s;
`endif

  state_e         state_q,     state_d;
  logic [2:0]     seg_idx_q,   seg_idx_d;
  logic [MRW-1:0] match_run_q, match_run_d;
  logic           locked_q,    locked_d;
  logic           err_q,       err_d;
  logic [CW-1:0]  last_len_q,  last_len_d;

  logic [NUM_SEG-1:0] hit_vec_s;
  logic               hunt_hit_s;
  logic [2:0]         hunt_idx_s;
  logic               seg_match_s;

  // Period search for HUNT and expected-segment compare for TRACK/LOCKED.
  always_comb begin
    for (int i = 0; i < NUM_SEG; i++) begin
      hit_vec_s[i] = (len_s == period_at(3'(i))) && (len_s != SAT);
    end
    // Exactly one hit is required; anything else is treated as no match.
    case (hit_vec_s)
      5'b00001: begin hunt_hit_s = 1'b1; hunt_idx_s = 3'd0; end
      5'b00010: begin hunt_hit_s = 1'b1; hunt_idx_s = 3'd1; end
      5'b00100: begin hunt_hit_s = 1'b1; hunt_idx_s = 3'd2; end
      5'b01000: begin hunt_hit_s = 1'b1; hunt_idx_s = 3'd3; end
      5'b10000: begin hunt_hit_s = 1'b1; hunt_idx_s = 3'd4; end
      default:  begin hunt_hit_s = 1'b0; hunt_idx_s = 3'd0; end
    endcase
    seg_match_s = (len_s == period_at(seg_idx_q)) && (len_s != SAT);
  end

  // Next-state and output logic of the sequence FSM.
  always_comb begin
    state_d     = state_q;
    seg_idx_d   = seg_idx_q;
    match_run_d = match_run_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    last_len_d  = last_len_q;
    case (state_q)
      ST_IDLE: begin
        // First tick is only a reference point.
        if (len_valid_s) state_d = ST_HUNT;
        else             state_d = ST_IDLE;
      end
      ST_HUNT: begin
        if (len_valid_s) begin
          last_len_d = len_s;
          if (hunt_hit_s) begin
            seg_idx_d   = next_seg(hunt_idx_s);
            match_run_d = MRW'(1);
            if (match_run_d >= MRW'(LOCK_COUNT)) begin
              locked_d = 1'b1;
              state_d  = ST_LOCKED;
            end else begin
              state_d  = ST_TRACK;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (len_valid_s) begin
          last_len_d = len_s;
          if (seg_match_s) begin
            seg_idx_d = next_seg(seg_idx_q);
            if (state_q == ST_TRACK) begin
              match_run_d = match_run_q + MRW'(1);
              if (match_run_d >= MRW'(LOCK_COUNT)) begin
                locked_d = 1'b1;
                state_d  = ST_LOCKED;
              end else begin
                state_d  = ST_TRACK;
              end
            end else begin
              state_d = ST_LOCKED;
            end
          end else begin
            // The mismatching tick doubles as the new reference.
            err_d       = 1'b1;
            locked_d    = 1'b0;
            match_run_d = '0;
            state_d     = ST_HUNT;
          end
        end
`ifdef PERIOD_CHK_TIMEOUT_EN
        else if (gap_at_max_s) begin
          err_d       = 1'b1;
          locked_d    = 1'b0;
          match_run_d = '0;
          state_d     = ST_IDLE;
        end
`endif
        else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seg_idx_q   <= 3'd0;
      match_run_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      last_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      seg_idx_q   <= seg_idx_d;
      match_run_q <= match_run_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      last_len_q  <= last_len_d;
    end
  end

  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.seg_idx  = seg_idx_q;
  assign bus.last_len = last_len_q;

endmodule

// File: tb/tb_period_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_period_seq_checker
// Self-checking bench for period_seq_checker. A reference model working from
// tick timestamps (interval = difference of tick cycle numbers) predicts the
// outputs; scenario tasks compare the DUT against the model and against
// directed expectations.
// -----------------------------------------------------------------------------
module tb_period_seq_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;

  period_seq_checker_if #(.CW(8)) bus ();

  period_seq_checker #(.CW(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int per [5] = '{13, 4, 2, 6, 11};

  // Reference model state (timestamp based).
  int cyc = 0;
  bit have_ref;
  int last_t;
  int pos;        // expected segment position, -1 when not yet identified
  int run;
  bit m_locked;
  bit m_err;
  int m_seg;
  int m_len;

  task automatic model_reset();
    have_ref = 1'b0;
    last_t   = 0;
    pos      = -1;
    run      = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_seg    = 0;
    m_len    = 0;
  endtask

  // One clock: drive tick/reset, let the edge pass, then advance the model.
  task automatic step(input bit t, input bit r);
    int len;
    int found;
    bus.tick = t;
    reset    = r;
    @(posedge clock);
    #1;
    cyc++;
    m_err = 1'b0;
    if (r) begin
      model_reset();
    end else if (t) begin
      if (!have_ref) begin
        have_ref = 1'b1;
        last_t   = cyc;
      end else begin
        len    = cyc - last_t;
        if (len > 255) len = 255;
        last_t = cyc;
        m_len  = len;
        if (pos < 0) begin
          found = -1;
          for (int i = 0; i < 5; i++) if (per[i] == len) found = i;
          if (found >= 0) begin
            pos   = (found + 1) % 5;
            m_seg = pos;
            run   = 1;
          end
        end else if (per[pos] == len) begin
          pos   = (pos + 1) % 5;
          m_seg = pos;
          if (!m_locked) begin
            run++;
            if (run >= 5) m_locked = 1'b1;
          end
        end else begin
          m_err    = 1'b1;
          m_locked = 1'b0;
          pos      = -1;
          run      = 0;
        end
      end
    end
`ifdef PERIOD_CHK_TIMEOUT_EN
    else if (pos >= 0 && (cyc - last_t - 1) == 64) begin
      m_err    = 1'b1;
      m_locked = 1'b0;
      pos      = -1;
      run      = 0;
      have_ref = 1'b0;
    end
`endif
  endtask

  // One interval of length L: L-1 idle cycles then the tick.
  task automatic send(input int len);
    for (int k = 0; k < len - 1; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if ({bus.locked, bus.err, bus.seg_idx, bus.last_len} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got locked=%b err=%b seg=%0d len=%0d, want all 0",
               bus.locked, bus.err, bus.seg_idx, bus.last_len);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_clean_stream();
    step(1'b1, 1'b0);   // reference
    checks++;
    if (bus.last_len !== 8'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL clean_ref: got len=%0d err=%b, want len=0 err=0", bus.last_len, bus.err);
    end
    for (int k = 0; k < 10; k++) begin
      send(per[k % 5]);
      checks++;
      if ({bus.locked, bus.err, bus.seg_idx, bus.last_len} !==
          {m_locked, m_err, 3'(m_seg), 8'(m_len)}) begin
        errors++;
        $display("FAIL clean_model k=%0d: got l=%b e=%b s=%0d len=%0d want l=%b e=%b s=%0d len=%0d",
                 k, bus.locked, bus.err, bus.seg_idx, bus.last_len, m_locked, m_err, m_seg, m_len);
      end
      checks++;
      if (bus.locked !== (k >= 4) || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL clean_lock k=%0d: got locked=%b err=%b, want locked=%b err=0",
                 k, bus.locked, bus.err, (k >= 4));
      end
    end
  endtask

  task automatic test_corrupt();
    send(13);
    send(5);            // segment of 4 lengthened to 5
    checks++;
    if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.last_len !== 8'd5) begin
      errors++;
      $display("FAIL corrupt_err: got err=%b locked=%b len=%0d, want err=1 locked=0 len=5",
               bus.err, bus.locked, bus.last_len);
    end
    step(1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_pulse: got err=%b one cycle later, want 0", bus.err);
    end
    step(1'b1, 1'b0);   // completes an interval of 2
    send(6);
    send(11);
    send(13);
    checks++;
    if (bus.locked !== 1'b0 || bus.seg_idx !== 3'd1) begin
      errors++;
      $display("FAIL corrupt_prelock: got locked=%b seg=%0d, want locked=0 seg=1",
               bus.locked, bus.seg_idx);
    end
    send(4);
    checks++;
    if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.locked !== m_locked) begin
      errors++;
      $display("FAIL corrupt_relock: got locked=%b err=%b, want locked=1 err=0",
               bus.locked, bus.err);
    end
  endtask

  task automatic test_mid_start();
    step(1'b0, 1'b1);
    model_reset();
    step(1'b1, 1'b0);   // reference
    send(6);
    checks++;
    if (bus.seg_idx !== 3'd4 || bus.last_len !== 8'd6 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL mid_hunt: got seg=%0d len=%0d locked=%b, want seg=4 len=6 locked=0",
               bus.seg_idx, bus.last_len, bus.locked);
    end
    send(11);
    checks++;
    if (bus.seg_idx !== 3'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_track: got seg=%0d err=%b, want seg=0 err=0", bus.seg_idx, bus.err);
    end
    send(13);
    send(4);
    send(2);
    checks++;
    if (bus.locked !== 1'b1 || bus.seg_idx !== 3'd3) begin
      errors++;
      $display("FAIL mid_lock: got locked=%b seg=%0d, want locked=1 seg=3", bus.locked, bus.seg_idx);
    end
  endtask

  task automatic test_reset_locked();
    step(1'b0, 1'b1);
    checks++;
    if ({bus.locked, bus.err, bus.seg_idx, bus.last_len} !== 13'd0) begin
      errors++;
      $display("FAIL reset_locked: got locked=%b err=%b seg=%0d len=%0d, want all 0",
               bus.locked, bus.err, bus.seg_idx, bus.last_len);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);   // reference only
    checks++;
    if (bus.last_len !== 8'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ref: got len=%0d err=%b, want len=0 err=0", bus.last_len, bus.err);
    end
    send(4);
    checks++;
    if ({bus.locked, bus.err, bus.seg_idx, bus.last_len} !==
        {m_locked, m_err, 3'(m_seg), 8'(m_len)}) begin
      errors++;
      $display("FAIL reset_hunt: got l=%b e=%b s=%0d len=%0d want l=%b e=%b s=%0d len=%0d",
               bus.locked, bus.err, bus.seg_idx, bus.last_len, m_locked, m_err, m_seg, m_len);
    end
  endtask

  task automatic test_tick_held();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (bus.err !== 1'b0 || bus.locked !== 1'b0 || bus.last_len !== 8'd1) begin
      errors++;
      $display("FAIL held_tick: got err=%b locked=%b len=%0d, want err=0 locked=0 len=1",
               bus.err, bus.locked, bus.last_len);
    end
    send(13);
    send(4);
    send(2);
    send(6);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL held_early: got locked=%b after 4 matches, want 0", bus.locked);
    end
    send(11);
    checks++;
    if (bus.locked !== 1'b1 || bus.locked !== m_locked) begin
      errors++;
      $display("FAIL held_lock: got locked=%b after 5 matches, want 1", bus.locked);
    end
  endtask

  task automatic test_stall();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 299; k++) begin
      step(1'b0, 1'b0);
      if (bus.err === 1'b1) pulses++;
    end
    checks++;
`ifdef PERIOD_CHK_TIMEOUT_EN
    if (pulses != 1 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL stall_timeout: got %0d err pulses locked=%b, want 1 pulse locked=0",
               pulses, bus.locked);
    end
`else
    if (pulses != 0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL stall_quiet: got %0d err pulses locked=%b, want 0 pulses locked=1",
               pulses, bus.locked);
    end
`endif
    step(1'b1, 1'b0);
    checks++;
    if ({bus.locked, bus.err, bus.seg_idx, bus.last_len} !==
        {m_locked, m_err, 3'(m_seg), 8'(m_len)}) begin
      errors++;
      $display("FAIL stall_tick: got l=%b e=%b s=%0d len=%0d want l=%b e=%b s=%0d len=%0d",
               bus.locked, bus.err, bus.seg_idx, bus.last_len, m_locked, m_err, m_seg, m_len);
    end
`ifndef PERIOD_CHK_TIMEOUT_EN
    checks++;
    if (bus.err !== 1'b1 || bus.last_len !== 8'd255) begin
      errors++;
      $display("FAIL stall_sat: got err=%b len=%0d, want err=1 len=255", bus.err, bus.last_len);
    end
`endif
  endtask

  task automatic test_random();
    int p;
    int len;
    step(1'b0, 1'b1);
    p = $urandom_range(4, 0);
    step(1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(99, 0) < 85) begin
        len = per[p];
        p   = (p + 1) % 5;
      end else begin
        len = $urandom_range(20, 1);
      end
      send(len);
      checks++;
      if ({bus.locked, bus.err, bus.seg_idx, bus.last_len} !==
          {m_locked, m_err, 3'(m_seg), 8'(m_len)}) begin
        errors++;
        $display("FAIL random k=%0d L=%0d: got l=%b e=%b s=%0d len=%0d want l=%b e=%b s=%0d len=%0d",
                 k, len, bus.locked, bus.err, bus.seg_idx, bus.last_len,
                 m_locked, m_err, m_seg, m_len);
      end
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    model_reset();
    test_reset();
    test_clean_stream();
    test_corrupt();
    test_mid_start();
    test_reset_locked();
    test_tick_held();
    test_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
